hilo_muldiv_unit: RTL and testbench
===================================

Name: hilo_muldiv_unit

Overview:
EX-stage consumer of the ALU FUNCT code for the HI/LO instruction class: MULT, MULTU, DIV, DIVU, MTHI and MTLO. It owns the architectural HI/LO registers. Multiplies and moves complete in one cycle. Divides run on an iterative restoring divider, and the unit raises a stall request toward the pipeline controller while the divide is in progress. MFHI/MFLO read the hi/lo outputs; forwarding of these values is outside this block.

Parameters:
DATA_WIDTH, 32, operand and HI/LO width; the divide iteration count equals DATA_WIDTH.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
start  in  1  EX holds a valid, non-bubble instruction this cycle
funct  in  6  FUNCT code from the decode-stage FUNCT generator (FUNCT_BUS)
flush  in  1  pipeline flush; cancels any in-flight divide
operand_1  in  DATA_WIDTH  rs value (dividend / multiplicand / MTHI/MTLO source)
operand_2  in  DATA_WIDTH  rt value (divisor / multiplier)
stall_req  out  1  combinational; hold IF/ID/EX this cycle
done  out  1  registered; one-cycle pulse when a divide result is committed
hi  out  DATA_WIDTH  registered HI
lo  out  DATA_WIDTH  registered LO

Behaviour:
- Interface: single clock clk. Reset rst is synchronous and active-high.
- Reset: state IDLE, hi=0, lo=0, done=0, iteration counter=0, stall_req=0.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1, flush=0, decoded by funct:
  - MULT: {hi,lo} <= signed 64-bit product at this edge. No stall.
  - MULTU: same, unsigned product.
  - MTHI: hi <= operand_1. MTLO: lo <= operand_1.
  - DIV/DIVU: latch operand magnitudes and signs, clear counter, go to RUN. stall_req=1 combinationally in this accept cycle (T0).
  - Any other funct: ignored; no state change.
- RUN, T1..T32:
  - One restoring-division iteration per cycle; stall_req=1.
  - At the edge ending T32: hi <= remainder, lo <= quotient, go to DONE.
- DONE, T33:
  - stall_req=0, done=1. start is ignored here, because the same divide instruction is still in EX.
  - Next state is IDLE.
- Total stall for a divide is 33 cycles (T0..T32).
- Signed divide:
  - Divide magnitudes.
  - Quotient sign = sign(op1) XOR sign(op2).
  - Remainder sign = sign(op1).
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wraps).
- Divisor zero (DIV and DIVU): full latency still applies; lo=0xFFFFFFFF, hi=operand_1 unmodified.
- flush:
  - Has priority over start.
  - In RUN: go to IDLE at the edge, hi/lo unchanged, stall_req=0 from the next cycle. stall_req is forced to 0 in the flush cycle itself.
  - In IDLE: suppresses any write.
  - In DONE: the result is already committed and is kept.
- rst mid-divide: same as reset; the divide is abandoned.
- hi/lo change only at clock edges. An MFHI issued in the cycle after DONE sees the new value.

Decomposition:
- funct.v (shared) holds FUNCT_MULT 6'h18, FUNCT_MULTU 6'h19, FUNCT_DIV 6'h1A, FUNCT_DIVU 6'h1B, FUNCT_MTHI 6'h11, FUNCT_MTLO 6'h13. It already carries the other FUNCT codes; add any missing ones there.
- FSM state encodings are local parameters in this block.
- Sub-module div_core: unsigned iterative restoring divider.
  - Interface: clk, rst, begin, cancel, dividend, divisor, quotient, remainder, ready.
  - Sign pre- and post-processing stays in hilo_muldiv_unit.

Test Plan:
- DIVU 7/2 -> stall_req high for exactly 33 cycles; done pulses in T33; then lo=3, hi=1.
- DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MULT 0xFFFFFFFF*2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE next edge. MULTU same operands -> hi=1, lo=0xFFFFFFFE. stall_req never asserted.
- MTHI 0x12345678 then MTLO 0xCAFEBABE -> hi/lo updated one edge each. Non-HI/LO funct (ADDU 6'h21) with start=1 -> no change.
- DIVU 100/7 with flush in T10 -> stall_req=0 from T11, hi/lo keep prior values, no done. A new DIVU starts cleanly in the next cycle. Repeat with rst in T10 -> hi=lo=0.
- DIVU 5/0 -> 33-cycle stall, lo=0xFFFFFFFF, hi=5. start held high during DONE does not restart the divide.

Source files
------------

// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared FUNCT codes for the ALU FUNCT bus and the HI/LO operation decode used by the EX-stage muldiv unit.
package hilo_muldiv_unit_pkg;

   localparam logic [5:0] FUNCT_MFHI  = 6'h10;
   localparam logic [5:0] FUNCT_MTHI  = 6'h11;
   localparam logic [5:0] FUNCT_MFLO  = 6'h12;
   localparam logic [5:0] FUNCT_MTLO  = 6'h13;
   localparam logic [5:0] FUNCT_MULT  = 6'h18;
   localparam logic [5:0] FUNCT_MULTU = 6'h19;
   localparam logic [5:0] FUNCT_DIV   = 6'h1A;
   localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
   localparam logic [5:0] FUNCT_ADD   = 6'h20;
   localparam logic [5:0] FUNCT_ADDU  = 6'h21;
   localparam logic [5:0] FUNCT_SUB   = 6'h22;
   localparam logic [5:0] FUNCT_SUBU  = 6'h23;

   typedef enum logic [2:0] {
      OP_NONE,
      OP_MULT,
      OP_MULTU,
      OP_DIV,
      OP_DIVU,
      OP_MTHI,
      OP_MTLO
   } hilo_op_t;

   function automatic hilo_op_t decode_op(input logic [5:0] funct);
      hilo_op_t op;
      case (funct)
         FUNCT_MULT:  op = OP_MULT;
         FUNCT_MULTU: op = OP_MULTU;
         FUNCT_DIV:   op = OP_DIV;
         FUNCT_DIVU:  op = OP_DIVU;
         FUNCT_MTHI:  op = OP_MTHI;
         FUNCT_MTLO:  op = OP_MTLO;
         default:     op = OP_NONE;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// EX-stage bundle between the pipeline (master) and the HI/LO muldiv unit (slave).
interface hilo_muldiv_unit_if #(parameter int DATA_WIDTH = 32);

   logic                  start;
   logic [5:0]            funct;
   logic                  flush;
   logic [DATA_WIDTH-1:0] operand_1;
   logic [DATA_WIDTH-1:0] operand_2;
   logic                  stall_req;
   logic                  done;
   logic [DATA_WIDTH-1:0] hi;
   logic [DATA_WIDTH-1:0] lo;

   modport master (
      output start, funct, flush, operand_1, operand_2,
      input  stall_req, done, hi, lo
   );

   modport slave (
      input  start, funct, flush, operand_1, operand_2,
      output stall_req, done, hi, lo
   );

endinterface

// File: rtl/hilo_muldiv_unit_div_core.sv
// Unsigned iterative restoring divider: one quotient bit per cycle, DATA_WIDTH cycles per divide.
module hilo_muldiv_unit_div_core #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_begin,
   input  logic                  i_cancel,
   input  logic [DATA_WIDTH-1:0] i_dividend,
   input  logic [DATA_WIDTH-1:0] i_divisor,
   output logic [DATA_WIDTH-1:0] o_quotient,
   output logic [DATA_WIDTH-1:0] o_remainder,
   output logic                  o_ready
);

   localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] LAST_ITER = CW'(DATA_WIDTH - 1);

   logic [DATA_WIDTH-1:0] r_quo;
   logic [DATA_WIDTH-1:0] r_rem;
   logic [DATA_WIDTH-1:0] r_div;
   logic [CW-1:0]         r_cnt;
   logic                  r_busy;

   logic [DATA_WIDTH:0]   w_shift;
   logic [DATA_WIDTH:0]   w_diff;
   logic [DATA_WIDTH-1:0] w_quo_next;
   logic [DATA_WIDTH-1:0] w_rem_next;

   // Partial remainder stays below the divisor, so one extra bit holds the trial subtraction's borrow.
   always_comb begin
      w_shift = {r_rem, r_quo[DATA_WIDTH-1]};
      w_diff  = w_shift - {1'b0, r_div};
      if (w_diff[DATA_WIDTH]) begin
         w_rem_next = w_shift[DATA_WIDTH-1:0];
         w_quo_next = {r_quo[DATA_WIDTH-2:0], 1'b0};
      end else begin
         w_rem_next = w_diff[DATA_WIDTH-1:0];
         w_quo_next = {r_quo[DATA_WIDTH-2:0], 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_quo  <= '0;
         r_rem  <= '0;
         r_div  <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
      end else if (i_cancel) begin
         r_cnt  <= '0;
         r_busy <= 1'b0;
      end else if (i_begin) begin
         r_quo  <= i_dividend;
         r_rem  <= '0;
         r_div  <= i_divisor;
         r_cnt  <= '0;
         r_busy <= 1'b1;
      end else if (r_busy) begin
         r_quo <= w_quo_next;
         r_rem <= w_rem_next;
         r_cnt <= r_cnt + 1'b1;
         if (r_cnt == LAST_ITER) begin
            r_busy <= 1'b0;
         end
      end
   end

   // Results are the outcome of the iteration in progress, so the owner can commit them on the final edge.
   assign o_quotient  = w_quo_next;
   assign o_remainder = w_rem_next;
   assign o_ready     = r_busy && (r_cnt == LAST_ITER);

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO owner for MULT/MULTU/DIV/DIVU/MTHI/MTLO; divides stall the pipeline while the iterative core runs.
module hilo_muldiv_unit
   import hilo_muldiv_unit_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input logic               clk,
   input logic               rst,
   hilo_muldiv_unit_if.slave bus
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]              r_state;
   logic [DATA_WIDTH-1:0]   r_hi;
   logic [DATA_WIDTH-1:0]   r_lo;
   logic                    r_done;
   logic [DATA_WIDTH-1:0]   r_op1;
   logic                    r_neg_q;
   logic                    r_neg_r;
   logic                    r_div_zero;

   hilo_op_t                w_op;
   logic                    w_is_div;
   logic                    w_accept;
   logic                    w_div_go;
   logic                    w_neg1;
   logic                    w_neg2;
   logic [DATA_WIDTH-1:0]   w_mag1;
   logic [DATA_WIDTH-1:0]   w_mag2;
   logic [2*DATA_WIDTH-1:0] w_prod_s;
   logic [2*DATA_WIDTH-1:0] w_prod_u;
   logic [DATA_WIDTH-1:0]   w_core_q;
   logic [DATA_WIDTH-1:0]   w_core_r;
   logic                    w_core_ready;
   logic [DATA_WIDTH-1:0]   w_quot_final;
   logic [DATA_WIDTH-1:0]   w_rem_final;

   assign w_op     = decode_op(bus.funct);
   assign w_is_div = (w_op == OP_DIV) || (w_op == OP_DIVU);
   assign w_accept = (r_state == ST_IDLE) && bus.start && !bus.flush;
   assign w_div_go = w_accept && w_is_div;

   assign w_neg1 = (w_op == OP_DIV) && bus.operand_1[DATA_WIDTH-1];
   assign w_neg2 = (w_op == OP_DIV) && bus.operand_2[DATA_WIDTH-1];
   assign w_mag1 = w_neg1 ? -bus.operand_1 : bus.operand_1;
   assign w_mag2 = w_neg2 ? -bus.operand_2 : bus.operand_2;

   assign w_prod_s = $signed({{DATA_WIDTH{bus.operand_1[DATA_WIDTH-1]}}, bus.operand_1})
                   * $signed({{DATA_WIDTH{bus.operand_2[DATA_WIDTH-1]}}, bus.operand_2});
   assign w_prod_u = {{DATA_WIDTH{1'b0}}, bus.operand_1} * {{DATA_WIDTH{1'b0}}, bus.operand_2};

   hilo_muldiv_unit_div_core #(.DATA_WIDTH(DATA_WIDTH)) u_div_core (
      .clk         (clk),
      .rst         (rst),
      .i_begin     (w_div_go),
      .i_cancel    (bus.flush),
      .i_dividend  (w_mag1),
      .i_divisor   (w_mag2),
      .o_quotient  (w_core_q),
      .o_remainder (w_core_r),
      .o_ready     (w_core_ready)
   );

   // A zero divisor yields all-ones quotient and the raw dividend as remainder, bypassing sign fix-up.
   assign w_quot_final = r_div_zero ? {DATA_WIDTH{1'b1}} : (r_neg_q ? -w_core_q : w_core_q);
   assign w_rem_final  = r_div_zero ? r_op1 : (r_neg_r ? -w_core_r : w_core_r);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_hi       <= '0;
         r_lo       <= '0;
         r_done     <= 1'b0;
         r_op1      <= '0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_div_zero <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  case (w_op)
                     OP_MULT:  {r_hi, r_lo} <= w_prod_s;
                     OP_MULTU: {r_hi, r_lo} <= w_prod_u;
                     OP_MTHI:  r_hi <= bus.operand_1;
                     OP_MTLO:  r_lo <= bus.operand_1;
                     OP_DIV, OP_DIVU: begin
                        r_op1      <= bus.operand_1;
                        r_neg_q    <= w_neg1 ^ w_neg2;
                        r_neg_r    <= w_neg1;
                        r_div_zero <= (bus.operand_2 == '0);
                        r_state    <= ST_RUN;
                     end
                     default: ;
                  endcase
               end
            end
            ST_RUN: begin
               if (bus.flush) begin
                  r_state <= ST_IDLE;
               end else if (w_core_ready) begin
                  r_hi    <= w_rem_final;
                  r_lo    <= w_quot_final;
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end
            end
            // The divide instruction is still in EX here, so start is deliberately not looked at.
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.stall_req = !rst && !bus.flush
                        && ((r_state == ST_RUN) || ((r_state == ST_IDLE) && bus.start && w_is_div));
   assign bus.done      = r_done;
   assign bus.hi        = r_hi;
   assign bus.lo        = r_lo;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: multiplies, moves, divides, flush/reset aborts and zero divisor.
module tb_hilo_muldiv_unit;
   import hilo_muldiv_unit_pkg::*;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   hilo_muldiv_unit_if #(.DATA_WIDTH(32)) bus ();

   hilo_muldiv_unit #(.DATA_WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One-cycle op: stall must stay low while it is presented; result visible after the edge.
   task automatic issue(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      bus.start     = 1'b1;
      bus.funct     = f;
      bus.operand_1 = a;
      bus.operand_2 = b;
      #1;
      check({tag, "_stall"}, {31'd0, bus.stall_req}, 32'd0);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      #1;
   endtask

   // Divide with start held through DONE, as the pipeline would; counts stall cycles T0..T32.
   task automatic run_div(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      int n;
      bus.start     = 1'b1;
      bus.funct     = f;
      bus.operand_1 = a;
      bus.operand_2 = b;
      #1;
      n = 0;
      while (bus.stall_req === 1'b1 && n < 100) begin
         n++;
         @(posedge clk);
         #1;
      end
      check({tag, "_stall_cycles"}, n, 32'd33);
      check({tag, "_done_T33"}, {31'd0, bus.done}, 32'd1);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      #1;
      check({tag, "_done_after"}, {31'd0, bus.done}, 32'd0);
      check({tag, "_stall_after"}, {31'd0, bus.stall_req}, 32'd0);
   endtask

   initial begin
      logic saw_done;
      checks        = 0;
      errors        = 0;
      rst           = 1'b1;
      bus.start     = 1'b0;
      bus.funct     = 6'h00;
      bus.flush     = 1'b0;
      bus.operand_1 = '0;
      bus.operand_2 = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_hi", bus.hi, 32'h0);
      check("reset_lo", bus.lo, 32'h0);
      check("reset_done", {31'd0, bus.done}, 32'd0);
      rst = 1'b0;
      #1;
      check("reset_stall", {31'd0, bus.stall_req}, 32'd0);

      issue("mult", FUNCT_MULT, 32'hFFFFFFFF, 32'h2);
      check("mult_hi", bus.hi, 32'hFFFFFFFF);
      check("mult_lo", bus.lo, 32'hFFFFFFFE);

      issue("multu", FUNCT_MULTU, 32'hFFFFFFFF, 32'h2);
      check("multu_hi", bus.hi, 32'h00000001);
      check("multu_lo", bus.lo, 32'hFFFFFFFE);

      issue("mthi", FUNCT_MTHI, 32'h12345678, 32'h0);
      check("mthi_hi", bus.hi, 32'h12345678);
      check("mthi_lo", bus.lo, 32'hFFFFFFFE);

      issue("mtlo", FUNCT_MTLO, 32'hCAFEBABE, 32'h0);
      check("mtlo_hi", bus.hi, 32'h12345678);
      check("mtlo_lo", bus.lo, 32'hCAFEBABE);

      issue("addu", FUNCT_ADDU, 32'h11111111, 32'h22222222);
      check("addu_hi", bus.hi, 32'h12345678);
      check("addu_lo", bus.lo, 32'hCAFEBABE);

      run_div("divu_7_2", FUNCT_DIVU, 32'd7, 32'd2);
      check("divu_7_2_lo", bus.lo, 32'd3);
      check("divu_7_2_hi", bus.hi, 32'd1);

      run_div("div_m7_2", FUNCT_DIV, 32'hFFFFFFF9, 32'd2);
      check("div_m7_2_lo", bus.lo, 32'hFFFFFFFD);
      check("div_m7_2_hi", bus.hi, 32'hFFFFFFFF);

      run_div("div_wrap", FUNCT_DIV, 32'h80000000, 32'hFFFFFFFF);
      check("div_wrap_lo", bus.lo, 32'h80000000);
      check("div_wrap_hi", bus.hi, 32'h00000000);

      // Flush in T10 abandons the divide with HI/LO untouched.
      bus.start     = 1'b1;
      bus.funct     = FUNCT_DIVU;
      bus.operand_1 = 32'd100;
      bus.operand_2 = 32'd7;
      repeat (10) @(posedge clk);
      #1;
      check("flush_pre_stall", {31'd0, bus.stall_req}, 32'd1);
      bus.flush = 1'b1;
      #1;
      check("flush_cycle_stall", {31'd0, bus.stall_req}, 32'd0);
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      bus.start = 1'b0;
      #1;
      check("flush_T11_stall", {31'd0, bus.stall_req}, 32'd0);
      check("flush_T11_done", {31'd0, bus.done}, 32'd0);
      check("flush_hi_kept", bus.hi, 32'h00000000);
      check("flush_lo_kept", bus.lo, 32'h80000000);
      @(posedge clk);
      #1;
      run_div("divu_100_7", FUNCT_DIVU, 32'd100, 32'd7);
      check("divu_100_7_lo", bus.lo, 32'd14);
      check("divu_100_7_hi", bus.hi, 32'd2);

      // Reset in T10 abandons the divide and clears HI/LO.
      bus.start     = 1'b1;
      bus.funct     = FUNCT_DIVU;
      bus.operand_1 = 32'd100;
      bus.operand_2 = 32'd7;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst       = 1'b0;
      bus.start = 1'b0;
      #1;
      check("rst_mid_hi", bus.hi, 32'h0);
      check("rst_mid_lo", bus.lo, 32'h0);
      check("rst_mid_stall", {31'd0, bus.stall_req}, 32'd0);
      saw_done = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (bus.done === 1'b1) saw_done = 1'b1;
         @(posedge clk);
         #1;
      end
      check("rst_mid_no_done", {31'd0, saw_done}, 32'd0);
      check("rst_mid_lo_stays", bus.lo, 32'h0);

      run_div("divu_5_0", FUNCT_DIVU, 32'd5, 32'd0);
      check("divu_5_0_lo", bus.lo, 32'hFFFFFFFF);
      check("divu_5_0_hi", bus.hi, 32'd5);

      issue("mult_neg", FUNCT_MULT, 32'd3, 32'hFFFFFFFC);
      check("mult_neg_hi", bus.hi, 32'hFFFFFFFF);
      check("mult_neg_lo", bus.lo, 32'hFFFFFFF4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
